if_fetch_unit: RTL and testbench

- Parametrised fetch stage: owns the PC, issues sequential instruction-memory requests and buffers responses in a DEPTH-entry in-order queue.
- Hands {inst, pc, pc4} to decode over a valid/ready handshake.
- A redirect (taken branch/jump from EX) flushes the queue and discards in-flight stale responses.
- Sits between the instruction memory and id_stage; replaces the combinational PC mux/adder path.

---
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage. It owns the PC, issues sequential imem
// requests under a credit limit and buffers responses in an in-order queue.
// The queue holds DEPTH entries and feeds decode over a valid/ready handshake.
// A redirect flushes the queue. Responses still in flight are marked stale and discarded.
// Optional feature macro: IF_PERF_CNT_EN adds the perf_fetched / perf_dropped counters.
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  // Stale requests can build up over back-to-back redirects, so this counter gets headroom.
  localparam int unsigned SW  = CW + 4;
  localparam int unsigned CW1 = CW + 1;

  logic [XLEN-1:0] r_fpc, r_rpc;
  logic [CW-1:0]   r_live, r_count;
  logic [SW-1:0]   r_stale;
  logic [PW-1:0]   r_head, r_tail;
  logic [31:0]     r_q_data [DEPTH];
  logic [XLEN-1:0] r_q_pc   [DEPTH];

  logic [XLEN-1:0] w_fpc_n, w_rpc_n;
  logic [CW-1:0]   w_live_n, w_count_n;
  logic [SW-1:0]   w_stale_n;
  logic [PW-1:0]   w_head_n, w_tail_n;

  logic            w_credit_ok;
  logic            w_req_fire;
  logic            w_has_stale;
  logic            w_resp_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_redir_resp;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused_addr_lsb;

  // Handshake qualifiers; a redirect cycle blocks issue, push and pop.
  assign w_credit_ok    = (CW1'(r_live) + CW1'(r_count)) < CW1'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && w_credit_ok;
  assign imem_req_addr  = r_fpc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_has_stale    = (r_stale != '0);
  assign w_resp_drop    = imem_resp_valid && w_has_stale;
  assign w_push         = imem_resp_valid && !w_has_stale && (r_live != '0) && !redirect_valid;
  assign w_pop          = inst_valid && inst_ready && !redirect_valid;
  assign w_redir_resp   = imem_resp_valid && (w_has_stale || (r_live != '0));
  assign w_redir_pc     = {redirect_addr[XLEN-1:2], 2'b00};
  assign w_unused_addr_lsb = &{1'b0, redirect_addr[1:0]};

  // Decode side reads straight from queue storage.
  assign inst_valid = (r_count != '0);
  assign inst_data  = r_q_data[r_head];
  assign inst_pc    = r_q_pc[r_head];
  assign inst_pc4   = inst_pc + XLEN'(4);

  // Next-state for PCs, credit counters and queue pointers.
  always_comb begin
    w_fpc_n   = r_fpc;
    w_rpc_n   = r_rpc;
    w_live_n  = r_live;
    w_stale_n = r_stale;
    w_count_n = r_count;
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    if (redirect_valid) begin
      w_fpc_n   = w_redir_pc;
      w_rpc_n   = w_redir_pc;
      w_live_n  = '0;
      w_count_n = '0;
      w_head_n  = '0;
      w_tail_n  = '0;
      w_stale_n = r_stale + SW'(r_live) - SW'(w_redir_resp);
    end else begin
      if (w_req_fire) w_fpc_n = r_fpc + XLEN'(4);
      if (w_push) begin
        w_rpc_n  = r_rpc + XLEN'(4);
        w_tail_n = r_tail + PW'(1);
      end
      if (w_pop) w_head_n = r_head + PW'(1);
      w_live_n  = r_live + CW'(w_req_fire) - CW'(w_push);
      w_stale_n = r_stale - SW'(w_resp_drop);
      w_count_n = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // State and queue storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_rpc   <= RESET_PC;
      r_live  <= '0;
      r_stale <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_data[PW'(i)] <= '0;
        r_q_pc[PW'(i)]   <= RESET_PC;
      end
    end else begin
      r_fpc   <= w_fpc_n;
      r_rpc   <= w_rpc_n;
      r_live  <= w_live_n;
      r_stale <= w_stale_n;
      r_count <= w_count_n;
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      if (w_push) begin
        r_q_data[r_tail] <= imem_resp_data;
        r_q_pc[r_tail]   <= r_rpc;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [CW1-1:0] w_drop_inc;
  logic [32:0]    w_fetched_sum, w_dropped_sum;
  logic [31:0]    r_perf_fetched, r_perf_dropped;

  // Increments: queued responses, and discarded responses plus flushed entries.
  always_comb begin
    w_drop_inc    = '0;
    w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_push);
    if (redirect_valid) w_drop_inc = CW1'(r_count) + CW1'(w_redir_resp);
    else                w_drop_inc = CW1'(w_resp_drop);
    w_dropped_sum = {1'b0, r_perf_dropped} + 33'(w_drop_inc);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      r_perf_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
      r_perf_dropped <= w_dropped_sum[32] ? '1 : w_dropped_sum[31:0];
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomised test of if_fetch_unit. It uses a
// behavioural imem with in-order variable latency and returns data = address.
// A scoreboard holds the expected PC of every accepted request.
module tb_if_fetch_unit;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  if_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc4        (inst_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_fire   = 0;
  int unsigned n_pop    = 0;
  int unsigned cyc      = 0;
  int unsigned last_due = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;
  int unsigned m_due;
  logic [31:0] m_exp;
  logic [31:0] exp_fpc  = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // imem model and scoreboard monitor; everything sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      sb.delete();
      exp_fpc         = RESET_PC;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      chk("credit_bound", 32'((32'(dut.r_live) + 32'(dut.r_count)) <= DEPTH), 32'd1);
      if (redirect_valid) begin
        chk("req_on_redirect", 32'(imem_req_valid), 32'd0);
        sb.delete();
        exp_fpc = {redirect_addr[31:2], 2'b00};
      end else begin
        if (inst_valid && inst_ready) begin
          n_pop++;
          chk("pop_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            m_exp = sb.pop_front();
            chk("inst_pc", inst_pc, m_exp);
            chk("inst_data", inst_data, m_exp);
            chk("inst_pc4", inst_pc4, m_exp + 32'd4);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          n_fire++;
          chk("req_addr", imem_req_addr, exp_fpc);
          sb.push_back(exp_fpc);
          m_due = cyc + $urandom_range(lat_max, lat_min);
          if (m_due <= last_due) m_due = last_due + 1;
          last_due = m_due;
          pend.push_back('{imem_req_addr, m_due});
          exp_fpc = exp_fpc + 32'd4;
        end
      end
    end
    cyc++;
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;

    // Reset state, then the sequential stream with single-cycle latency.
    tick();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_inst_data", inst_data, 32'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h100);
    chk("t1_inst_valid0", 32'(inst_valid), 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_pc0", inst_pc, 32'h100);
    chk("t1_pc4_0", inst_pc4, 32'h104);
    chk("t1_data0", inst_data, 32'h100);
    tick(); @(negedge clk); chk("t1_pc1", inst_pc, 32'h104);
    tick(); @(negedge clk); chk("t1_pc2", inst_pc, 32'h108);

    // Redirect together with a response and inst_ready=1.
    tick(); redirect_valid = 1'b1; redirect_addr = 32'h3000;
    @(negedge clk);
    chk("t4_pre_valid", 32'(inst_valid), 32'd1);
    chk("t4_pre_resp", 32'(imem_resp_valid), 32'd1);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h3000);
    tick(); tick(); @(negedge clk);
    chk("t4_first_pc", inst_pc, 32'h3000);

    // PC wrap at the top of the address space.
    tick(); redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF9;
    tick(); redirect_valid = 1'b0;
    tick(); tick(); @(negedge clk);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    tick(); @(negedge clk);
    chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", inst_pc4, 32'h0);
    tick(); @(negedge clk);
    chk("wrap_pc2", inst_pc, 32'h0);

    // Decode stalled: the credit limit stops issue at DEPTH requests.
    tick(); reset = 1'b1; inst_ready = 1'b0; n_fire = 0;
    tick(); tick(); reset = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("t2_fires", n_fire, 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_count", 32'(dut.r_count), 32'd4);
    chk("t2_head", inst_pc, 32'h100);
    tick(); inst_ready = 1'b1;
    @(negedge clk); chk("t2_d0", inst_pc, 32'h100);
    tick(); @(negedge clk); chk("t2_d1", inst_pc, 32'h104);
    tick(); @(negedge clk); chk("t2_d2", inst_pc, 32'h108);
    tick(); @(negedge clk); chk("t2_d3", inst_pc, 32'h10C);

    // Redirect to an unaligned target with three live requests and a non-empty queue.
    tick(); reset = 1'b1; inst_ready = 1'b0; lat_min = 5; lat_max = 5;
    tick(); tick(); reset = 1'b0;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_addr = 32'h2003;
    @(negedge clk);
    chk("t3_live", 32'(dut.r_live), 32'd3);
    chk("t3_qvalid", 32'(inst_valid), 32'd1);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_stale", 32'(dut.r_stale), 32'd2);
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    chk("t3_req_addr", imem_req_addr, 32'h2000);
    tick(); inst_ready = 1'b1;
    @(negedge clk); chk("t3_no_stale_out", 32'(inst_valid), 32'd0);
    repeat (5) tick();
    @(negedge clk);
    chk("t3_first_valid", 32'(inst_valid), 32'd1);
    chk("t3_first_pc", inst_pc, 32'h2000);

    // Reset while the queue is full.
    tick(); inst_ready = 1'b0; lat_min = 1; lat_max = 1;
    repeat (15) tick();
    @(negedge clk);
    chk("t6_full", 32'(dut.r_count), 32'd4);
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("t6_req_in_rst", 32'(imem_req_valid), 32'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_req_addr", imem_req_addr, RESET_PC);
    chk("t6_inst_pc", inst_pc, RESET_PC);
`ifdef IF_PERF_CNT_EN
    chk("t6_perf_fetched", perf_fetched, 32'd0);
    chk("t6_perf_dropped", perf_dropped, 32'd0);
`endif

    // Random ready/latency with periodic redirects.
    lat_min = 1; lat_max = 5; n_pop = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(3, 0) != 0);
      if ((i % 10) == 9) begin
        redirect_valid = 1'b1;
        redirect_addr  = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("t5_delivered", 32'(n_pop != 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
